// File: rtl/bpu_pkg.sv
// Shared definitions for the branch predictor: 2-bit counter encodings
// and the saturating counter update used by the BTB training path.
package bpu_pkg;

    localparam logic [1:0] CTR_SNT   = 2'b00;  // strongly not-taken
    localparam logic [1:0] CTR_WNT   = 2'b01;  // weakly not-taken
    localparam logic [1:0] CTR_WT    = 2'b10;  // weakly taken
    localparam logic [1:0] CTR_ST    = 2'b11;  // strongly taken
    localparam logic [1:0] CTR_RESET = CTR_WNT;

    // Saturating step: 11 stays 11 on taken, 00 stays 00 on not-taken.
    function automatic logic [1:0] sat_update(input logic [1:0] ctr, input logic taken);
        logic [1:0] nxt;
        nxt = ctr;
        if (taken) begin
            if (ctr != CTR_ST) nxt = ctr + 2'd1;
        end else begin
            if (ctr != CTR_SNT) nxt = ctr - 2'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/bpu_table.sv
// BTB storage: ENTRIES x {valid, tag, target, 2-bit counter}.
// Two asynchronous read ports (lookup and update) and one write port.
// Entry fields and counters have separate indices so the counter array
// can be hashed with global history while tag/target stay PC-indexed.
module bpu_table
    import bpu_pkg::*;
#(
    parameter int ENTRIES = 16,
    parameter int IDX_W   = 4,
    parameter int TAG_W   = 26
) (
    input  logic             clk,
    input  logic             rst_n,
    // lookup read port
    input  logic [IDX_W-1:0] lk_idx_i,
    input  logic [IDX_W-1:0] lk_ctr_idx_i,
    output logic             lk_valid_o,
    output logic [TAG_W-1:0] lk_tag_o,
    output logic [31:0]      lk_target_o,
    output logic [1:0]       lk_ctr_o,
    // update read port
    input  logic [IDX_W-1:0] up_idx_i,
    input  logic [IDX_W-1:0] up_ctr_idx_i,
    output logic             up_valid_o,
    output logic [TAG_W-1:0] up_tag_o,
    output logic [1:0]       up_ctr_o,
    // write port
    input  logic             we_entry_i,
    input  logic             we_ctr_i,
    input  logic [IDX_W-1:0] wr_idx_i,
    input  logic [IDX_W-1:0] wr_ctr_idx_i,
    input  logic [TAG_W-1:0] wr_tag_i,
    input  logic [31:0]      wr_target_i,
    input  logic [1:0]       wr_ctr_i
);

    logic [ENTRIES-1:0] valid_q, valid_d;
    logic [TAG_W-1:0]   tag_q    [ENTRIES];
    logic [TAG_W-1:0]   tag_d    [ENTRIES];
    logic [31:0]        target_q [ENTRIES];
    logic [31:0]        target_d [ENTRIES];
    logic [1:0]         ctr_q    [ENTRIES];
    logic [1:0]         ctr_d    [ENTRIES];

    // Asynchronous reads return the pre-write contents (read-old).
    assign lk_valid_o  = valid_q[lk_idx_i];
    assign lk_tag_o    = tag_q[lk_idx_i];
    assign lk_target_o = target_q[lk_idx_i];
    assign lk_ctr_o    = ctr_q[lk_ctr_idx_i];
    assign up_valid_o  = valid_q[up_idx_i];
    assign up_tag_o    = tag_q[up_idx_i];
    assign up_ctr_o    = ctr_q[up_ctr_idx_i];

    // Next-state: a written entry always becomes valid with the new tag/target.
    always_comb begin
        valid_d  = valid_q;
        tag_d    = tag_q;
        target_d = target_q;
        ctr_d    = ctr_q;
        if (we_entry_i) begin
            valid_d[wr_idx_i]  = 1'b1;
            tag_d[wr_idx_i]    = wr_tag_i;
            target_d[wr_idx_i] = wr_target_i;
        end
        if (we_ctr_i) begin
            ctr_d[wr_ctr_idx_i] = wr_ctr_i;
        end
    end

    // Storage registers; async reset clears entries and sets weak not-taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= CTR_RESET;
            end
        end else begin
            valid_q  <= valid_d;
            tag_q    <= tag_d;
            target_q <= target_d;
            ctr_q    <= ctr_d;
        end
    end

endmodule

// File: rtl/branch_predictor_btb.sv
// Direct-mapped BTB with 2-bit counters, combinational IF lookup and
// registered ID training, plus branch / mispredict performance counters.
// Optional gshare counter indexing is enabled by defining BPU_GSHARE_EN.
//
// Update interface: upd_valid_i qualifies all upd_* inputs for one cycle.
// There is no ready; the update is applied at the clock edge only when
// upd_valid_i=1 and stall_i=0. A stalled update is simply not applied.
module branch_predictor_btb
    import bpu_pkg::*;
#(
    parameter int ENTRIES = 16
`ifdef BPU_GSHARE_EN
    ,
    parameter int GHR_W   = $clog2(ENTRIES)
`endif
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall_i,
    input  logic [31:0] lookup_pc_i,
    output logic        pred_taken_o,
    output logic [31:0] pred_target_o,
    input  logic        upd_valid_i,
    input  logic [31:0] upd_pc_i,
    input  logic        upd_taken_i,
    input  logic [31:0] upd_target_i,
    input  logic        upd_pred_taken_i,
`ifdef BPU_GSHARE_EN
    input  logic [GHR_W-1:0] upd_ghr_i,
`endif
    output logic        mispredict_o,
    output logic [31:0] perf_branches_o,
    output logic [31:0] perf_mispred_o
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = 30 - IDX_W;

    logic [IDX_W-1:0] lk_idx, lk_ctr_idx, up_idx, up_ctr_idx;
    logic [TAG_W-1:0] lk_tag, up_tag;
    logic             lk_valid, up_valid;
    logic [TAG_W-1:0] lk_tag_rd, up_tag_rd;
    logic [31:0]      lk_target;
    logic [1:0]       lk_ctr, up_ctr;
    logic             lk_hit, up_hit, upd_en;
    logic             we_entry, we_ctr;
    logic [1:0]       wr_ctr;
    logic [31:0]      perf_branches_q, perf_branches_d;
    logic [31:0]      perf_mispred_q, perf_mispred_d;
    logic             unused_pc_lsbs;

    // Byte offset of the PC never selects an entry.
    assign unused_pc_lsbs = ^{lookup_pc_i[1:0], upd_pc_i[1:0]};

    assign lk_idx = lookup_pc_i[IDX_W+1:2];
    assign lk_tag = lookup_pc_i[31:IDX_W+2];
    assign up_idx = upd_pc_i[IDX_W+1:2];
    assign up_tag = upd_pc_i[31:IDX_W+2];
    assign upd_en = upd_valid_i & ~stall_i;

`ifdef BPU_GSHARE_EN
    logic [GHR_W-1:0] ghr_q, ghr_d;

    assign lk_ctr_idx = lk_idx ^ IDX_W'(ghr_q);
    assign up_ctr_idx = up_idx ^ IDX_W'(upd_ghr_i);

    // Global history shifts in each applied outcome.
    always_comb begin
        ghr_d = ghr_q;
        if (upd_en) ghr_d = {ghr_q[GHR_W-2:0], upd_taken_i};
    end

    // History register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ghr_q <= '0;
        else        ghr_q <= ghr_d;
    end
`else
    assign lk_ctr_idx = lk_idx;
    assign up_ctr_idx = up_idx;
`endif

    bpu_table #(
        .ENTRIES (ENTRIES),
        .IDX_W   (IDX_W),
        .TAG_W   (TAG_W)
    ) u_table (
        .clk          (clk),
        .rst_n        (rst_n),
        .lk_idx_i     (lk_idx),
        .lk_ctr_idx_i (lk_ctr_idx),
        .lk_valid_o   (lk_valid),
        .lk_tag_o     (lk_tag_rd),
        .lk_target_o  (lk_target),
        .lk_ctr_o     (lk_ctr),
        .up_idx_i     (up_idx),
        .up_ctr_idx_i (up_ctr_idx),
        .up_valid_o   (up_valid),
        .up_tag_o     (up_tag_rd),
        .up_ctr_o     (up_ctr),
        .we_entry_i   (we_entry),
        .we_ctr_i     (we_ctr),
        .wr_idx_i     (up_idx),
        .wr_ctr_idx_i (up_ctr_idx),
        .wr_tag_i     (up_tag),
        .wr_target_i  (upd_target_i),
        .wr_ctr_i     (wr_ctr)
    );

    assign lk_hit        = lk_valid & (lk_tag_rd == lk_tag);
    assign up_hit        = up_valid & (up_tag_rd == up_tag);
    assign pred_taken_o  = lk_hit & lk_ctr[1];
    assign pred_target_o = lk_hit ? lk_target : 32'd0;
    assign mispredict_o  = upd_valid_i & (upd_taken_i != upd_pred_taken_i);

    // Training decision: train on hit, allocate only on a taken miss.
    always_comb begin
        we_entry = 1'b0;
        we_ctr   = 1'b0;
        wr_ctr   = up_ctr;
        if (upd_en) begin
            if (up_hit) begin
                we_ctr   = 1'b1;
                wr_ctr   = sat_update(up_ctr, upd_taken_i);
                we_entry = upd_taken_i;
            end else if (upd_taken_i) begin
                we_entry = 1'b1;
                we_ctr   = 1'b1;
                wr_ctr   = CTR_WT;
            end
        end
    end

    // Performance counters advance once per applied update, wrapping at 2^32.
    always_comb begin
        perf_branches_d = perf_branches_q;
        perf_mispred_d  = perf_mispred_q;
        if (upd_en) begin
            perf_branches_d = perf_branches_q + 32'd1;
            if (mispredict_o) perf_mispred_d = perf_mispred_q + 32'd1;
        end
    end

    // Performance counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_branches_q <= '0;
            perf_mispred_q  <= '0;
        end else begin
            perf_branches_q <= perf_branches_d;
            perf_mispred_q  <= perf_mispred_d;
        end
    end

    assign perf_branches_o = perf_branches_q;
    assign perf_mispred_o  = perf_mispred_q;

endmodule

// File: tb/tb_branch_predictor_btb.sv
// Self-checking bench for branch_predictor_btb (ENTRIES=16).
// Directed scenarios use literal expectations; the random phase uses a
// small reference model of the predictor behaviour. With BPU_GSHARE_EN
// defined, only the reset and history-indexing scenarios run.
module tb_branch_predictor_btb;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall_i;
    logic [31:0] lookup_pc_i;
    logic        pred_taken_o;
    logic [31:0] pred_target_o;
    logic        upd_valid_i;
    logic [31:0] upd_pc_i;
    logic        upd_taken_i;
    logic [31:0] upd_target_i;
    logic        upd_pred_taken_i;
    logic        mispredict_o;
    logic [31:0] perf_branches_o;
    logic [31:0] perf_mispred_o;
`ifdef BPU_GSHARE_EN
    logic [3:0]  upd_ghr_i;
`endif

    always #5 clk = ~clk;

    branch_predictor_btb dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .stall_i          (stall_i),
        .lookup_pc_i      (lookup_pc_i),
        .pred_taken_o     (pred_taken_o),
        .pred_target_o    (pred_target_o),
        .upd_valid_i      (upd_valid_i),
        .upd_pc_i         (upd_pc_i),
        .upd_taken_i      (upd_taken_i),
        .upd_target_i     (upd_target_i),
        .upd_pred_taken_i (upd_pred_taken_i),
`ifdef BPU_GSHARE_EN
        .upd_ghr_i        (upd_ghr_i),
`endif
        .mispredict_o     (mispredict_o),
        .perf_branches_o  (perf_branches_o),
        .perf_mispred_o   (perf_mispred_o)
    );

    // ---------------- scoreboard ----------------
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [32:0] exp_q[$];

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h expected=%h", tag, act, exp);
        end
    endtask

    // ---------------- reference model (PC-indexed) ----------------
    logic        m_valid  [16];
    logic [25:0] m_tag    [16];
    logic [31:0] m_target [16];
    logic [1:0]  m_ctr    [16];
    logic [31:0] m_br, m_mis;

    task automatic model_reset();
        for (int i = 0; i < 16; i++) begin
            m_valid[i] = 1'b0; m_tag[i] = '0; m_target[i] = '0; m_ctr[i] = 2'b01;
        end
        m_br = 0; m_mis = 0;
    endtask

    function automatic logic [32:0] model_predict(input logic [31:0] pc);
        logic [3:0] idx;
        idx = pc[5:2];
        if (m_valid[idx] && m_tag[idx] == pc[31:6]) return {m_ctr[idx][1], m_target[idx]};
        return 33'd0;
    endfunction

    task automatic model_update(input logic [31:0] pc, input logic taken,
                                input logic [31:0] target, input logic pred);
        logic [3:0] idx;
        idx = pc[5:2];
        m_br = m_br + 1;
        if (taken != pred) m_mis = m_mis + 1;
        if (m_valid[idx] && m_tag[idx] == pc[31:6]) begin
            if (taken) begin
                if (m_ctr[idx] != 2'b11) m_ctr[idx] = m_ctr[idx] + 2'd1;
                m_target[idx] = target;
            end else if (m_ctr[idx] != 2'b00) begin
                m_ctr[idx] = m_ctr[idx] - 2'd1;
            end
        end else if (taken) begin
            m_valid[idx] = 1'b1; m_tag[idx] = pc[31:6];
            m_target[idx] = target; m_ctr[idx] = 2'b10;
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic apply_reset();
        rst_n = 1'b0; stall_i = 1'b0; upd_valid_i = 1'b0; upd_pc_i = '0;
        upd_taken_i = 1'b0; upd_target_i = '0; upd_pred_taken_i = 1'b0;
        lookup_pc_i = '0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
    endtask

    task automatic do_update(input logic [31:0] pc, input logic taken, input logic [31:0] target,
                             input logic pred, input logic stall);
        @(negedge clk);
        upd_valid_i = 1'b1; upd_pc_i = pc; upd_taken_i = taken;
        upd_target_i = target; upd_pred_taken_i = pred; stall_i = stall;
        #1 check("mispredict", 64'(mispredict_o), 64'(taken != pred));
        @(posedge clk);
        if (!stall) model_update(pc, taken, target, pred);
        #1;
        upd_valid_i = 1'b0; stall_i = 1'b0;
    endtask

    task automatic do_lookup(input logic [31:0] pc, input logic exp_t, input logic [31:0] exp_tgt);
        logic [32:0] e;
        @(negedge clk);
        lookup_pc_i = pc;
        exp_q.push_back({exp_t, exp_tgt});
        #1;
        e = exp_q.pop_front();
        check($sformatf("lookup_%h", pc), 64'({pred_taken_o, pred_target_o}), 64'(e));
    endtask

    task automatic check_perf(input logic [31:0] br, input logic [31:0] mis);
        check("perf_branches", 64'(perf_branches_o), 64'(br));
        check("perf_mispred", 64'(perf_mispred_o), 64'(mis));
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        apply_reset();
        do_lookup(32'h40, 1'b0, 32'h0);
        check_perf(0, 0);

`ifdef BPU_GSHARE_EN
        // Four taken updates at 0x40 with the carried history snapshot.
        upd_ghr_i = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            do_update(32'h40, 1'b1, 32'h80, 1'b0, 1'b0);
            upd_ghr_i = {upd_ghr_i[2:0], 1'b1};
        end
        // GHR is now 1111: lookup reads untouched counter 0xF (weak not-taken).
        do_lookup(32'h40, 1'b0, 32'h80);
        do_update(32'h40, 1'b1, 32'h80, 1'b0, 1'b0);
        do_lookup(32'h40, 1'b1, 32'h80);
        check_perf(5, 5);
`else
        // Allocate on taken miss.
        do_update(32'h40, 1'b1, 32'h80, 1'b0, 1'b0);
        do_lookup(32'h40, 1'b1, 32'h80);
        check_perf(1, 1);

        // Not-taken training 10 -> 01 -> 00 -> 00.
        do_update(32'h40, 1'b0, 32'h0, 1'b1, 1'b0);
        do_lookup(32'h40, 1'b0, 32'h80);
        do_update(32'h40, 1'b0, 32'h0, 1'b0, 1'b0);
        do_lookup(32'h40, 1'b0, 32'h80);
        do_update(32'h40, 1'b0, 32'h0, 1'b0, 1'b0);
        do_lookup(32'h40, 1'b0, 32'h80);
        // One taken from saturated 00 only reaches 01, still not-taken.
        do_update(32'h40, 1'b1, 32'h80, 1'b0, 1'b0);
        do_lookup(32'h40, 1'b0, 32'h80);
        check_perf(5, 3);

        // Alias at 0x440 with a same-cycle lookup of 0x40 (read-old).
        @(negedge clk);
        lookup_pc_i = 32'h40;
        upd_valid_i = 1'b1; upd_pc_i = 32'h440; upd_taken_i = 1'b1;
        upd_target_i = 32'h500; upd_pred_taken_i = 1'b0; stall_i = 1'b0;
        #1;
        exp_q.push_back({1'b0, 32'h80});
        check("alias_read_old", 64'({pred_taken_o, pred_target_o}), 64'(exp_q.pop_front()));
        @(posedge clk);
        model_update(32'h440, 1'b1, 32'h500, 1'b0);
        #1 upd_valid_i = 1'b0;
        do_lookup(32'h40, 1'b0, 32'h0);
        do_lookup(32'h440, 1'b1, 32'h500);
        check_perf(6, 4);

        // Stalled update must not change anything.
        do_update(32'h48, 1'b1, 32'h100, 1'b0, 1'b1);
        do_lookup(32'h48, 1'b0, 32'h0);
        check_perf(6, 4);

        // upd_valid_i=0 with live-looking upd_* inputs.
        @(negedge clk);
        upd_valid_i = 1'b0; upd_pc_i = 32'h48; upd_taken_i = 1'b1;
        upd_target_i = 32'h100; upd_pred_taken_i = 1'b0;
        #1 check("mispredict_idle", 64'(mispredict_o), 64'(0));
        @(posedge clk);
        do_lookup(32'h48, 1'b0, 32'h0);
        check_perf(6, 4);

        // Random phase against the reference model.
        apply_reset();
        for (int i = 0; i < 300; i++) begin
            logic [31:0] pc, lpc, tgt;
            logic [32:0] mp;
            logic        tk, pr, st;
            pc  = ($urandom_range(0, 2) << 6) | ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
            tgt = $urandom;
            tk  = 1'($urandom_range(0, 1));
            mp  = model_predict(pc);
            pr  = ($urandom_range(0, 3) == 0) ? 1'($urandom_range(0, 1)) : mp[32];
            st  = ($urandom_range(0, 7) == 0);
            do_update(pc, tk, tgt, pr, st);
            lpc = ($urandom_range(0, 2) << 6) | ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
            mp  = model_predict(lpc);
            do_lookup(lpc, mp[32], mp[31:0]);
            if (i % 25 == 24) check_perf(m_br, m_mis);
        end
        check_perf(m_br, m_mis);

        // Asynchronous reset mid-run, away from any clock edge.
        do_update(32'h44, 1'b1, 32'h1234, 1'b0, 1'b0);
        @(negedge clk) lookup_pc_i = 32'h44;
        #1 check("pre_reset_taken", 64'({pred_taken_o, pred_target_o}), 64'({1'b1, 32'h1234}));
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("async_reset_pred", 64'({pred_taken_o, pred_target_o}), 64'(0));
        check_perf(0, 0);
        model_reset();
        @(negedge clk) rst_n = 1'b1;
        do_lookup(32'h44, 1'b0, 32'h0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
